// File: rtl/mp_mem_arb.sv
// Shared single-port memory behind a round-robin arbiter, with byte-enable writes,
// registered reads, out-of-range error strobes and a post-reset clear sequencer.
module mp_mem_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_DEPTH  = 3072
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_PORTS-1:0]              valid_i,
  input  logic [NUM_PORTS-1:0]              op_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wr_data_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  output logic [NUM_PORTS-1:0]              ready_o,
  output logic [NUM_PORTS-1:0]              rd_valid_o,
  output logic [DATA_WIDTH-1:0]             rd_data_o,
  output logic                              rd_err_o,
  output logic                              wr_err_o,
  output logic                              init_done_o
);

  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int NB  = DATA_WIDTH / 8;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [MAW-1:0]          clr_cnt_q, clr_cnt_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_err_q, rd_err_d;
  logic                    wr_err_q, wr_err_d;
  logic                    init_done_q;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    gnt_any;
  logic [PW-1:0]           gnt_idx;
  logic [PW-1:0]           cand_idx;
  logic                    gnt_op;
  logic [ADDR_WIDTH-1:0]   gnt_addr;
  logic [DATA_WIDTH-1:0]   gnt_wdata;
  logic [NB-1:0]           gnt_be;
  logic                    in_range;
  logic [MAW-1:0]          mem_addr;

  // Rotating priority search starting at ptr_q; only live once the clear has finished.
  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand_idx = PW'((int'(ptr_q) + i) % NUM_PORTS);
        if (!gnt_any && valid_i[cand_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (gnt_any) ready_o[gnt_idx] = 1'b1;
  end

  assign gnt_op    = op_i[gnt_idx];
  assign gnt_addr  = addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign gnt_wdata = wr_data_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_be    = be_i[int'(gnt_idx)*NB +: NB];
  assign in_range  = 32'(gnt_addr) < MEM_DEPTH;
  assign mem_addr  = gnt_addr[MAW-1:0];

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    ptr_d      = ptr_q;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    rd_err_d   = 1'b0;
    wr_err_d   = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == MAW'(MEM_DEPTH - 1)) begin
        state_d   = ST_RUN;
        clr_cnt_d = '0;
      end
    end else if (gnt_any) begin
      ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
      if (gnt_op) begin
        wr_err_d = !in_range;
      end else begin
        rd_valid_d = ready_o;
        rd_err_d   = !in_range;
        rd_data_d  = in_range ? mem[mem_addr] : '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      ptr_q       <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ptr_q       <= ptr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
      wr_err_q    <= wr_err_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (gnt_any && gnt_op && in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (gnt_be[k]) mem[mem_addr][k*8 +: 8] <= gnt_wdata[k*8 +: 8];
      end
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_err_o    = rd_err_q;
  assign wr_err_o    = wr_err_q;
  assign init_done_o = init_done_q;

endmodule

// File: doc/mp_mem_arb.md
Name: mp_mem_arb

Overview:
- Shared single-port memory serving NUM_PORTS requesters through a round-robin arbiter with valid/ready handshakes.
- Successor to the two-port arbitrated memory. Adds:
  - parametrised port count, width and depth
  - byte-enable writes
  - registered read with a per-port read-valid strobe
  - out-of-range error reporting
  - a hardware memory-clear sequencer that runs after every reset

Parameters:
- NUM_PORTS, 4, number of requesting ports (2..8)
- DATA_WIDTH, 32, data word width in bits (multiple of 8)
- ADDR_WIDTH, 12, address width per port
- MEM_DEPTH, 3072, number of implemented words (MEM_DEPTH <= 2**ADDR_WIDTH)

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- valid_i  input  NUM_PORTS  per-port request valid
- op_i  input  NUM_PORTS  per-port op: 1 = write, 0 = read
- addr_i  input  NUM_PORTS*ADDR_WIDTH  packed addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- wr_data_i  input  NUM_PORTS*DATA_WIDTH  packed write data
- be_i  input  NUM_PORTS*DATA_WIDTH/8  packed byte enables
- ready_o  output  NUM_PORTS  one-hot grant; request accepted when valid_i[p] && ready_o[p]
- rd_valid_o  output  NUM_PORTS  one-hot pulse; read data for port p is valid
- rd_data_o  output  DATA_WIDTH  shared read data bus
- rd_err_o  output  1  qualifies rd_data_o; set when the accepted read address >= MEM_DEPTH
- wr_err_o  output  1  one-cycle pulse the cycle after a write to address >= MEM_DEPTH is accepted
- init_done_o  output  1  high when the clear sequence is complete and the block is serving requests

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. While rstn = 0:
  - ready_o = 0, rd_valid_o = 0, rd_data_o = 0, rd_err_o = 0, wr_err_o = 0, init_done_o = 0
  - state = CLEAR, clear counter = 0, round-robin pointer = 0
- State machine:
  - CLEAR: write all-zero to word clr_cnt each cycle and increment clr_cnt. After writing word MEM_DEPTH-1, go to RUN. Clear takes exactly MEM_DEPTH cycles after rstn deasserts.
  - RUN: init_done_o = 1; the arbiter is active.
  - There is no exit from RUN except reset.
- Arbitration (RUN only, combinational on valid_i):
  - Search ports starting at index ptr, wrapping modulo NUM_PORTS; the first p with valid_i[p] = 1 gets ready_o[p] = 1.
  - At most one ready_o bit is set. ready_o = 0 when no port is valid.
  - On acceptance, ptr <= (granted + 1) mod NUM_PORTS. With no grant, ptr holds.
  - ready_o is 0 for every port during CLEAR.
  - Requesters hold valid_i and payload stable until accepted.
- Write (accepted, op = 1):
  - Addr < MEM_DEPTH: byte lane k updates when be_i bit k = 1; the new value is visible to reads accepted from the next cycle onward.
  - Addr >= MEM_DEPTH: memory is unchanged; wr_err_o pulses for one cycle on the next edge.
  - A write with be = 0 is accepted and changes nothing.
- Read (accepted, op = 0):
  - Latency 1. On the next edge: rd_valid_o[granted] = 1 for exactly one cycle, and rd_data_o = mem[addr].
  - Out-of-range read: rd_data_o = 0 and rd_err_o = 1.
  - When no read was accepted, rd_data_o holds its last value and rd_err_o = 0.
- Back-to-back: one access per cycle sustained. A read accepted the cycle after a write to the same address returns the written data.
- Reset mid-operation:
  - Any in-flight read is dropped: no rd_valid_o pulse.
  - The block re-enters CLEAR and all memory contents are zeroed again.

Test Plan:
- Reset release, no traffic -> init_done_o rises exactly 3072 cycles after rstn deasserts; read of addr 0x0BFF returns 0x00000000 with rd_err_o = 0.
- Ports 0-3 all valid continuously, reads -> grants in order 0,1,2,3,0,…; each port receives one rd_valid_o per 4 cycles.
- Port 1 writes 0xDEADBEEF with be = 4'b1111 to 0x010, then writes 0x000000AA with be = 4'b0001 to the same address; port 2 then reads 0x010 -> rd_data_o = 0xDEADBEAA one cycle after acceptance, rd_valid_o = 4'b0100.
- Port 3 writes addr 0xC00 -> wr_err_o pulses once, memory unchanged. Port 3 then reads 0xC00 -> rd_data_o = 0 with rd_err_o = 1.
- valid_i = 4'b1010 with ptr = 0 -> port 1 granted, ptr = 2. Next cycle same valid_i -> port 3 granted, ptr = 0.
- Read accepted, then rstn asserted before the next edge -> no rd_valid_o pulse, init_done_o = 0, ready_o = 0. After release, previously written words read as 0.
